// File: rtl/hc4_regarb_pkg.sv
// Shared definitions for the register-file write arbiter.
// Port-select encoding used for the round-robin pointer and lock owner,
// plus the default bank geometry.
package hc4_regarb_pkg;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_sel_t;

  localparam int REGARB_WIDTH = 4;
  localparam int REGARB_NREG  = 4;
  localparam int REGARB_AW    = 2;

endpackage

// File: rtl/regarb_onehot_dec.sv
// Purpose: address + valid -> active-low one-hot register enable, plus out-of-range flag.
// Latency: purely combinational, feeds the nWrEn flops in the arbiter.
// Backpressure: none; an out-of-range address yields an all-ones vector (write dropped).
module regarb_onehot_dec
  import hc4_regarb_pkg::*;
#(
  parameter int NREG = REGARB_NREG,
  parameter int AW   = REGARB_AW
) (
  input  logic [AW-1:0]   addr,
  input  logic            vld,
  output logic [NREG-1:0] n_onehot,
  output logic            out_of_range
);

  // One extra bit so NREG == 2**AW still compares correctly.
  localparam logic [AW:0] NREG_W = (AW+1)'(NREG);

  // Decode the address into a single low bit; nothing low when invalid or out of range.
  always_comb begin
    n_onehot     = '1;
    out_of_range = vld && ({1'b0, addr} >= NREG_W);
    for (int i = 0; i < NREG; i++) begin
      if (vld && (addr == AW'(i))) begin
        n_onehot[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Purpose: round-robin arbiter for the shared register-file write path (ports A and B).
// Latency: one cycle from sampled req to registered gnt/nWrEn/wdata; all outputs from flops.
// Backpressure: loser simply waits; a port is ineligible the cycle its own gnt is high.
// Optional owner lock for back-to-back writes is enabled by defining REGARB_LOCK_EN.
module regfile_write_arbiter
  import hc4_regarb_pkg::*;
#(
  parameter int WIDTH = REGARB_WIDTH,
  parameter int NREG  = REGARB_NREG,
  parameter int AW    = REGARB_AW
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             reqA,
  input  logic             reqB,
  input  logic [AW-1:0]    addrA,
  input  logic [AW-1:0]    addrB,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic             lockA,
  input  logic             lockB,
  output logic             gntA,
  output logic             gntB,
  output logic [WIDTH-1:0] wdata,
  output logic [NREG-1:0]  nWrEn,
  output logic             addrErr
);

  port_sel_t        last_q, last_d;
  logic             gnt_a_q, gnt_a_d;
  logic             gnt_b_q, gnt_b_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [NREG-1:0]  nwren_q, nwren_d;
  logic             addr_err_q, addr_err_d;

  logic             elig_a, elig_b;
  logic             win_a, win_b, win_any;
  logic [AW-1:0]    win_addr;
  logic [NREG-1:0]  dec_n;
  logic             dec_oor;

`ifdef REGARB_LOCK_EN
  logic             lock_vld_q, lock_vld_d;
  port_sel_t        lock_own_q, lock_own_d;
`else
  // Lock inputs exist on the port list but have no function in this build.
  logic             unused_lock;
  assign unused_lock = lockA | lockB;
`endif

  // Eligibility (bubble after own grant, lock exclusion) and round-robin pick.
  always_comb begin
    elig_a = reqA & ~gnt_a_q;
    elig_b = reqB & ~gnt_b_q;
`ifdef REGARB_LOCK_EN
    if (lock_vld_q) begin
      if (lock_own_q == PORT_A) begin
        elig_b = 1'b0;
      end else begin
        elig_a = 1'b0;
      end
    end
`endif
    win_a    = elig_a & (~elig_b | (last_q == PORT_B));
    win_b    = elig_b & (~elig_a | (last_q == PORT_A));
    win_any  = win_a | win_b;
    win_addr = win_b ? addrB : addrA;
  end

  regarb_onehot_dec #(
    .NREG (NREG),
    .AW   (AW)
  ) u_dec (
    .addr         (win_addr),
    .vld          (win_any),
    .n_onehot     (dec_n),
    .out_of_range (dec_oor)
  );

  // Next-state for grant pulses, write bus, enables and the round-robin pointer.
  always_comb begin
    gnt_a_d    = win_a;
    gnt_b_d    = win_b;
    nwren_d    = dec_n;
    addr_err_d = dec_oor;
    wdata_d    = wdata_q;
    last_d     = last_q;
    if (win_a) begin
      wdata_d = dataA;
      last_d  = PORT_A;
    end else if (win_b) begin
      wdata_d = dataB;
      last_d  = PORT_B;
    end
  end

`ifdef REGARB_LOCK_EN
  // A grant sets or releases ownership according to the winner's lock bit;
  // the non-owner can never win while a lock is held, so no owner check is needed here.
  always_comb begin
    lock_vld_d = lock_vld_q;
    lock_own_d = lock_own_q;
    if (win_a) begin
      lock_vld_d = lockA;
      lock_own_d = PORT_A;
    end else if (win_b) begin
      lock_vld_d = lockB;
      lock_own_d = PORT_B;
    end
  end

  // Lock owner state; reset leaves no owner.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      lock_vld_q <= 1'b0;
      lock_own_q <= PORT_A;
    end else begin
      lock_vld_q <= lock_vld_d;
      lock_own_q <= lock_own_d;
    end
  end
`endif

  // Output and pointer flops; reset drops any pending enable immediately.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      last_q     <= PORT_B;
      gnt_a_q    <= 1'b0;
      gnt_b_q    <= 1'b0;
      wdata_q    <= '0;
      nwren_q    <= '1;
      addr_err_q <= 1'b0;
    end else begin
      last_q     <= last_d;
      gnt_a_q    <= gnt_a_d;
      gnt_b_q    <= gnt_b_d;
      wdata_q    <= wdata_d;
      nwren_q    <= nwren_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign gntA    = gnt_a_q;
  assign gntB    = gnt_b_q;
  assign wdata   = wdata_q;
  assign nWrEn   = nwren_q;
  assign addrErr = addr_err_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: the stimulus queues expected
// grants (cycle, port, data, enables); a negedge monitor pops and compares them.
module tb_regfile_write_arbiter;

  logic       clk = 1'b0;
  logic       nReset;
  logic       reqA, reqB, lockA, lockB;
  logic [1:0] addrA, addrB;
  logic [3:0] dataA, dataB;
  logic       gntA, gntB, addrErr;
  logic [3:0] wdata, nWrEn;

  // Second instance with a 3-register bank for the out-of-range case.
  logic       reqB3;
  logic [1:0] addrB3;
  logic [3:0] dataB3;
  logic       gntA3, gntB3, addrErr3;
  logic [3:0] wdata3;
  logic [2:0] nWrEn3;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.WIDTH(4), .NREG(4), .AW(2)) dut (
    .clk(clk), .nReset(nReset),
    .reqA(reqA), .reqB(reqB), .addrA(addrA), .addrB(addrB),
    .dataA(dataA), .dataB(dataB), .lockA(lockA), .lockB(lockB),
    .gntA(gntA), .gntB(gntB), .wdata(wdata), .nWrEn(nWrEn), .addrErr(addrErr)
  );

  regfile_write_arbiter #(.WIDTH(4), .NREG(3), .AW(2)) dut3 (
    .clk(clk), .nReset(nReset),
    .reqA(1'b0), .reqB(reqB3), .addrA(2'd0), .addrB(addrB3),
    .dataA(4'h0), .dataB(dataB3), .lockA(1'b0), .lockB(1'b0),
    .gntA(gntA3), .gntB(gntB3), .wdata(wdata3), .nWrEn(nWrEn3), .addrErr(addrErr3)
  );

  typedef struct {
    int         cyc;
    bit         port;
    logic [3:0] data;
    logic [3:0] nwr;
    bit         err;
  } exp_t;

  exp_t       q[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc    = 0;
  logic [3:0] bank [4];

  always @(posedge clk) cyc <= cyc + 1;

  // Model of the register bank: a register captures wdata when its enable is low.
  initial for (int i = 0; i < 4; i++) bank[i] = 4'h0;
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) if (!nWrEn[i]) bank[i] <= wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic expect_wr(input int c, input bit p, input logic [3:0] d, input logic [3:0] nw);
    q.push_back('{c, p, d, nw, 1'b0});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every grant must match the head of the scoreboard; idle cycles keep enables high.
  always @(negedge clk) begin : mon
    exp_t e;
    if (nReset) begin
      chk("gnt_exclusive", 32'(gntA & gntB), 32'd0);
      if (gntA || gntB) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant: actual cyc=%0d gntA=%0b gntB=%0b required no grant",
                   cyc, gntA, gntB);
        end else begin
          e = q.pop_front();
          chk("grant_cycle",   32'(cyc),     32'(e.cyc));
          chk("grant_port",    32'(gntB),    32'(e.port));
          chk("grant_wdata",   32'(wdata),   32'(e.data));
          chk("grant_nwren",   32'(nWrEn),   32'(e.nwr));
          chk("grant_addrerr", 32'(addrErr), 32'(e.err));
        end
      end else begin
        chk("idle_nwren",   32'(nWrEn),   32'hF);
        chk("idle_addrerr", 32'(addrErr), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int c;
    nReset = 1'b0;
    reqA = 0; reqB = 0; lockA = 0; lockB = 0;
    addrA = 0; addrB = 0; dataA = 0; dataB = 0;
    reqB3 = 0; addrB3 = 0; dataB3 = 0;

    // Reset values
    repeat (3) step();
    chk("rst_gntA",    32'(gntA),    32'd0);
    chk("rst_gntB",    32'(gntB),    32'd0);
    chk("rst_nwren",   32'(nWrEn),   32'hF);
    chk("rst_wdata",   32'(wdata),   32'd0);
    chk("rst_addrerr", 32'(addrErr), 32'd0);
    nReset = 1'b1;

    // Idle after release
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_gnts",  32'({gntA, gntB}), 32'd0);
      chk("idle_wdata", 32'(wdata),        32'd0);
    end

    // Tie: both held; A wins first (pointer resets to B), then strict alternation
    c = cyc;
    reqA = 1; addrA = 2'd0; dataA = 4'h5;
    reqB = 1; addrB = 2'd3; dataB = 4'hC;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) expect_wr(c + 1 + k, 1'b0, 4'h5, 4'b1110);
      else            expect_wr(c + 1 + k, 1'b1, 4'hC, 4'b0111);
    end
    repeat (6) step();
    reqA = 0; reqB = 0;
    repeat (2) step();
    chk("tie_bank0", 32'(bank[0]), 32'h5);
    chk("tie_bank3", 32'(bank[3]), 32'hC);

    // Single A write to register 2
    c = cyc;
    reqA = 1; addrA = 2'd2; dataA = 4'hA;
    expect_wr(c + 1, 1'b0, 4'hA, 4'b1011);
    step();
    chk("single_gntA",  32'(gntA),  32'd1);
    chk("single_nwren", 32'(nWrEn), 32'b1011);
    chk("single_wdata", 32'(wdata), 32'hA);
    reqA = 0;
    repeat (2) step();
    chk("single_bank2", 32'(bank[2]), 32'hA);

    // Bubble: A alone held for 6 cycles -> 1,0,1,0,1,0
    c = cyc;
    reqA = 1; addrA = 2'd1; dataA = 4'h3;
    expect_wr(c + 1, 1'b0, 4'h3, 4'b1101);
    expect_wr(c + 3, 1'b0, 4'h3, 4'b1101);
    expect_wr(c + 5, 1'b0, 4'h3, 4'b1101);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("bubble_gntA", 32'(gntA), (k % 2 == 0) ? 32'd1 : 32'd0);
    end
    reqA = 0;
    repeat (2) step();

    // Out-of-range on the 3-register instance, then an in-range write
    reqB3 = 1; addrB3 = 2'd3; dataB3 = 4'h7;
    step();
    chk("oor_gntB",    32'(gntB3),    32'd1);
    chk("oor_addrerr", 32'(addrErr3), 32'd1);
    chk("oor_nwren",   32'(nWrEn3),   32'b111);
    chk("oor_wdata",   32'(wdata3),   32'h7);
    chk("oor_gntA",    32'(gntA3),    32'd0);
    reqB3 = 0;
    step();
    chk("oor_pulse_end", 32'({gntB3, addrErr3}), 32'd0);
    reqB3 = 1; addrB3 = 2'd2; dataB3 = 4'h6;
    step();
    chk("inr_nwren",   32'(nWrEn3),   32'b011);
    chk("inr_addrerr", 32'(addrErr3), 32'd0);
    reqB3 = 0;
    repeat (2) step();

    // Lock sequence: A grabs with lockA=1 while B requests
    c = cyc;
    reqA = 1; lockA = 1; addrA = 2'd1; dataA = 4'h9;
`ifdef REGARB_LOCK_EN
    expect_wr(c + 1, 1'b0, 4'h9, 4'b1101);
    expect_wr(c + 3, 1'b0, 4'h9, 4'b1101);
    expect_wr(c + 5, 1'b0, 4'h8, 4'b1101);
    expect_wr(c + 6, 1'b1, 4'h6, 4'b1011);
`else
    expect_wr(c + 1, 1'b0, 4'h9, 4'b1101);
    expect_wr(c + 2, 1'b1, 4'h6, 4'b1011);
    expect_wr(c + 3, 1'b0, 4'h9, 4'b1101);
    expect_wr(c + 4, 1'b1, 4'h6, 4'b1011);
    expect_wr(c + 5, 1'b0, 4'h8, 4'b1101);
    expect_wr(c + 6, 1'b1, 4'h6, 4'b1011);
`endif
    step();
    reqB = 1; addrB = 2'd2; dataB = 4'h6;
    repeat (2) step();
    lockA = 0; dataA = 4'h8;
    repeat (2) step();
    reqA = 0;
    step();
    reqB = 0;
    repeat (2) step();

    // Reset asserted while an enable is low: enable clears, no capture
    c = cyc;
    reqA = 1; addrA = 2'd0; dataA = 4'hF;
    expect_wr(c + 1, 1'b0, 4'hF, 4'b1110);
    step();
    chk("pre_rst_nwren", 32'(nWrEn), 32'b1110);
    #5;
    nReset = 1'b0;
    reqA = 0;
    #1;
    chk("mid_rst_nwren", 32'(nWrEn), 32'hF);
    chk("mid_rst_gntA",  32'(gntA),  32'd0);
    chk("mid_rst_wdata", 32'(wdata), 32'd0);
    repeat (2) step();
    chk("mid_rst_bank0", 32'(bank[0]), 32'h5);
    nReset = 1'b1;
    repeat (3) step();
    chk("post_rst_gnts", 32'({gntA, gntB}), 32'd0);

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
